// File: rtl/pattern_seq_pkg.sv
// pattern_seq shared types and constants.
// Sequencer state encoding and the decade table for the slot timebase.
package pattern_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_RUN,
      S_DONE
   } state_t;

   localparam int POW_W = 26;

   localparam logic [POW_W-1:0] POW10 [8] = '{
      26'd1,
      26'd10,
      26'd100,
      26'd1000,
      26'd10000,
      26'd100000,
      26'd1000000,
      26'd10000000
   };

endpackage

// File: rtl/pattern_seq_timebase.sv
// Slot timebase: a decade prescaler followed by a stage-1 divider.
// slot_end pulses on the last clock of every slot.
module pattern_seq_timebase
   import pattern_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic [3:0] stage1_div,
   input  logic [2:0] timestep_sel,
   output logic       slot_end
);

   logic [POW_W-1:0] pre_cnt;
   logic [POW_W-1:0] pre_max;
   logic [3:0]       div_cnt;
   logic [3:0]       div_max;
   logic             pre_tick;

   always_comb begin
      pre_max = POW10[timestep_sel] - POW_W'(1);
      div_max = (stage1_div == 4'd0) ? 4'd0 : stage1_div - 4'd1;
      // a one-clock slot is stretched to two
      if (timestep_sel == 3'd0 && div_max == 4'd0)
         div_max = 4'd1;
      pre_tick = (pre_cnt == pre_max);
      slot_end = pre_tick && (div_cnt == div_max);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         div_cnt <= '0;
      end else if (clear) begin
         pre_cnt <= '0;
         div_cnt <= '0;
      end else if (pre_tick) begin
         pre_cnt <= '0;
         div_cnt <= (div_cnt == div_max) ? 4'd0 : div_cnt + 4'd1;
      end else begin
         pre_cnt <= pre_cnt + POW_W'(1);
      end
   end

endmodule

// File: rtl/pattern_seq.sv
// SRAM-backed pattern sequencer driving gpio_out slice by slice.
// One word is prefetched while the current word is being shifted out.
module pattern_seq
   import pattern_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 19,
   parameter int PASS_W = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 stop,
   input  logic [ADDR_W-1:0]                    cfg_start_addr,
   input  logic [ADDR_W-1:0]                    cfg_end_addr,
   input  logic [$clog2($clog2(DATA_W)+1)-1:0]  cfg_lane_sel,
   input  logic                                 cfg_lsb_first,
   input  logic [PASS_W-1:0]                    cfg_passes,
   input  logic [3:0]                           cfg_stage1_div,
   input  logic [2:0]                           cfg_timestep_sel,
   input  logic [DATA_W-1:0]                    cfg_idle_value,
   output logic [ADDR_W-1:0]                    sram_addr,
   input  logic [DATA_W-1:0]                    sram_data,
   output logic                                 pattern_active,
   output logic                                 pattern_done,
   output logic                                 cfg_err,
   output logic [PASS_W-1:0]                    pass_count,
   output logic [DATA_W-1:0]                    gpio_out
);

   localparam int LOG_DW = $clog2(DATA_W);
   localparam int LS_W   = $clog2(LOG_DW + 1);
   localparam logic [LS_W-1:0] LS_MAX = LS_W'(LOG_DW);

   state_t state;
   state_t state_d;

   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] nxt_addr;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] pf_word;
   logic [DATA_W-1:0] nxt_word;
   logic [DATA_W-1:0] lane_mask;
   logic [LOG_DW-1:0] slice;
   logic [LOG_DW:0]   lanes;
   logic [LS_W-1:0]   ls;
   logic [PASS_W-1:0] pc_inc;
   logic [1:0]        rd_wait;
   logic              fetch_cnt;
   logic              slot_end;
   logic              tb_clear;
   logic              last_slice;
   logic              addr_ok;

   logic start_ok;
   logic start_bad;
   logic fetch_step;
   logic first_load;
   logic slice_step;
   logic word_end;
   logic word_next;
   logic pass_end;
   logic finish;

   assign tb_clear = (state != S_RUN);

   pattern_seq_timebase u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (tb_clear),
      .stage1_div   (cfg_stage1_div),
      .timestep_sel (cfg_timestep_sel),
      .slot_end     (slot_end)
   );

   assign ls         = (cfg_lane_sel > LS_MAX) ? LS_MAX : cfg_lane_sel;
   assign lanes      = (LOG_DW+1)'(1) << ls;
   assign lane_mask  = ~({DATA_W{1'b1}} << lanes);
   assign last_slice = (slice == LOG_DW'((DATA_W >> ls) - 1));
   assign addr_ok    = (cfg_start_addr <= cfg_end_addr);
   assign nxt_addr   = (sram_addr == cfg_end_addr) ? cfg_start_addr
                                                  : sram_addr + ADDR_W'(1);
   // read data is live for exactly one cycle before it lands in pf_word
   assign nxt_word   = (rd_wait == 2'd1) ? sram_data : pf_word;
   assign pc_inc     = (&pass_count) ? pass_count : pass_count + PASS_W'(1);

   assign pattern_active = (state == S_FETCH) || (state == S_RUN);

   function automatic logic [DATA_W-1:0] slice_of(
      input logic [DATA_W-1:0] w,
      input logic [LOG_DW-1:0] k
   );
      logic [DATA_W-1:0] src;
      for (int j = 0; j < DATA_W; j++)
         src[j] = cfg_lsb_first ? w[j] : w[DATA_W-1-j];
      return (src >> (k << ls)) & lane_mask;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d    = state;
      start_ok   = 1'b0;
      start_bad  = 1'b0;
      fetch_step = 1'b0;
      first_load = 1'b0;
      slice_step = 1'b0;
      word_end   = 1'b0;
      word_next  = 1'b0;
      pass_end   = 1'b0;
      finish     = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               start_ok  = start && addr_ok;
               start_bad = start && !addr_ok;
               if (start_ok)
                  state_d = S_FETCH;
            end
            S_FETCH: begin
               fetch_step = !fetch_cnt;
               first_load = fetch_cnt;
               if (fetch_cnt)
                  state_d = S_RUN;
            end
            S_RUN: begin
               slice_step = slot_end && !last_slice;
               word_end   = slot_end && last_slice;
               pass_end   = word_end && (cur_addr == cfg_end_addr);
               finish     = pass_end && (cfg_passes != '0)
                            && (pc_inc == cfg_passes);
               word_next  = word_end && !finish;
               if (finish)
                  state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_addr    <= '0;
         cur_addr     <= '0;
         cur_word     <= '0;
         pf_word      <= '0;
         slice        <= '0;
         rd_wait      <= '0;
         fetch_cnt    <= 1'b0;
         pattern_done <= 1'b0;
         cfg_err      <= 1'b0;
         pass_count   <= '0;
         gpio_out     <= '0;
      end else begin
         if (rd_wait != 2'd0)
            rd_wait <= rd_wait - 2'd1;
         if (rd_wait == 2'd1)
            pf_word <= sram_data;
         if (stop || state == S_IDLE || state == S_DONE)
            gpio_out <= cfg_idle_value;
         unique case (1'b1)
            start_ok: begin
               sram_addr    <= cfg_start_addr;
               cur_addr     <= cfg_start_addr;
               fetch_cnt    <= 1'b0;
               slice        <= '0;
               rd_wait      <= 2'd0;
               pattern_done <= 1'b0;
               cfg_err      <= 1'b0;
               pass_count   <= '0;
            end
            start_bad: cfg_err <= 1'b1;
            fetch_step: begin
               fetch_cnt <= 1'b1;
               sram_addr <= nxt_addr;
               rd_wait   <= 2'd2;
            end
            first_load: begin
               cur_word <= sram_data;
               slice    <= '0;
               gpio_out <= slice_of(sram_data, '0);
            end
            slice_step: begin
               slice    <= slice + LOG_DW'(1);
               gpio_out <= slice_of(cur_word, slice + LOG_DW'(1));
            end
            finish: begin
               pass_count   <= pc_inc;
               pattern_done <= 1'b1;
               gpio_out     <= cfg_idle_value;
            end
            word_next: begin
               if (pass_end)
                  pass_count <= pc_inc;
               cur_word  <= nxt_word;
               cur_addr  <= sram_addr;
               sram_addr <= nxt_addr;
               rd_wait   <= 2'd2;
               slice     <= '0;
               gpio_out  <= slice_of(nxt_word, '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/pattern_seq.md
PATTERN_SEQ -- requirements
Module: pattern_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, SRAM word width and maximum lane count (power of 2, ≥2).
REQ-002 SHALL have parameter ADDR_W, default 19, SRAM address width.
REQ-003 SHALL have parameter PASS_W, default 16, pass-counter width.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  in  1  single-cycle start request.
REQ-007 SHALL have port stop  in  1  synchronous abort.
REQ-008 SHALL have ports cfg_start_addr and cfg_end_addr, each  in  ADDR_W  first and last word, both inclusive.
REQ-009 SHALL have port cfg_lane_sel  in  $clog2($clog2(DATA_W)+1)  lanes = 2^sel; values above log2(DATA_W) clamp to DATA_W.
REQ-010 SHALL have port cfg_lsb_first  in  1  slice order.
REQ-011 SHALL have port cfg_passes  in  PASS_W  0 = continuous; N = exactly N passes.
REQ-012 SHALL have ports cfg_stage1_div  in  4  and cfg_timestep_sel  in  3  slot length = max(cfg_stage1_div,1) × 10^cfg_timestep_sel clocks, with a minimum of 2.
REQ-013 SHALL have port cfg_idle_value  in  DATA_W  gpio value when not running.
REQ-014 SHALL have port sram_addr  out  ADDR_W  read address; read data arrives one clock later.
REQ-015 SHALL have port sram_data  in  DATA_W  read data.
REQ-016 SHALL have port pattern_active  out  1  high in FETCH/RUN; SRAM is owned by this block.
REQ-017 SHALL have port pattern_done  out  1  sticky completion flag.
REQ-018 SHALL have port cfg_err  out  1  sticky: start rejected because cfg_start_addr > cfg_end_addr.
REQ-019 SHALL have port pass_count  out  PASS_W  completed passes, saturating.
REQ-020 SHALL have port gpio_out  out  DATA_W  registered pattern output.

Function
REQ-021 SHALL implement states IDLE, FETCH, RUN and DONE.
REQ-022 IDLE→FETCH SHALL occur on start when the addresses are valid: sram_addr = cfg_start_addr; clear pattern_done, cfg_err and pass_count.
REQ-023 FETCH→RUN SHALL occur after 2 clocks; gpio_out SHALL show slice 0 of the start word after the 3rd rising edge following start.
REQ-024 MSB-first: SHALL drive gpio_out[i] = word[DATA_W-1-k·L-i] for slice k and lane count L. LSB-first: SHALL drive gpio_out[i] = word[k·L+i]. gpio_out[DATA_W-1:L] SHALL be 0 in RUN.
REQ-025 SHALL hold each slice for exactly one slot; a word has DATA_W/L slices.
REQ-026 SHALL keep a prefetch register: the next word is fetched while the current word is loaded. Word boundaries SHALL have no gaps, including at L = DATA_W with a 2-clock slot.
REQ-027 Next-word address SHALL wrap from cfg_end_addr to cfg_start_addr; pass_count SHALL increment when the last slice of cfg_end_addr completes.
REQ-028 At the end of the final pass (pass_count reaches cfg_passes ≠ 0), SHALL go RUN→DONE: gpio_out = cfg_idle_value and pattern_done = 1, held until the next accepted start.
REQ-029 cfg_passes = 0 SHALL loop until stop.
REQ-030 stop in any state SHALL return to IDLE next clock: gpio_out = cfg_idle_value; pattern_done unchanged. stop SHALL win over a simultaneous start.
REQ-031 start SHALL be ignored while in FETCH or RUN. start in DONE SHALL restart.
REQ-032 start with cfg_start_addr > cfg_end_addr SHALL stay in IDLE and set cfg_err.
REQ-033 cfg_start_addr == cfg_end_addr SHALL be legal: a single-word pattern.
REQ-034 Config changes during FETCH/RUN are unsupported; behaviour SHALL only be guaranteed after stop.
REQ-035 The slot timebase SHALL reset on FETCH entry, so the first slot is full length.

Reset
REQ-036 On rst_n low: state = IDLE; gpio_out = 0; sram_addr = 0; pattern_active = 0; pattern_done = 0; cfg_err = 0; pass_count = 0; all counters = 0.
REQ-037 Reset mid-RUN SHALL abort immediately, with no done flag after release.

Structure
REQ-038 Package pattern_seq_pkg SHALL hold the state enum and the 10^n slot-count table (26-bit constants).
REQ-039 Sub-module pattern_seq_timebase SHALL generate the slot-end pulse from cfg_stage1_div/cfg_timestep_sel and a clear input.

Verification
REQ-040 DATA_W=8; word 0xA5 at address 0; start = end = 0; L=1; MSB-first; passes=1; div=2; sel=0 -> gpio_out[0] = 1,0,1,0,0,1,0,1, each 2 clocks; then done=1 and gpio=idle.
REQ-041 Words 0x12,0x34 at addresses 4–5; L=8; passes=3; slot 2 -> gpio = 12,34,12,34,12,34 with no gaps; pass_count=3.
REQ-042 L=2, LSB-first, word 0xE4, slot 10 -> gpio[1:0] = 0,1,2,3, each 10 clocks.
REQ-043 passes=0; stop asserted mid-slot with start in the same cycle -> IDLE next clock; gpio=cfg_idle_value; done=0.
REQ-044 start=7, end=3 -> stays IDLE; cfg_err=1; sram_addr unchanged.
REQ-045 rst_n pulsed low mid-RUN -> all outputs at reset values, asynchronously; no done flag after release.
